// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared LEGv8 core types and constants
package core_pkg;

   localparam int N_DEFAULT = 64;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
   localparam logic [31:0] INSTR_HLT = 32'hD440_0000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - pipeline register for {instr, pc, valid}; clr (bubble) beats en (load)
module ifid_reg
   import core_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [31:0]  instr,
   input  logic [N-1:0] pc,
   input  logic         valid,
   output logic [31:0]  instr_r,
   output logic [N-1:0] pc_r,
   output logic         valid_r
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_r <= INSTR_NOP;
         pc_r    <= '0;
         valid_r <= 1'b0;
      end else if (clr) begin
         instr_r <= INSTR_NOP;
         pc_r    <= '0;
         valid_r <= 1'b0;
      end else if (en) begin
         instr_r <= instr;
         pc_r    <= pc;
         valid_r <= valid;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction fetch: PC, next-PC mux, HLT park FSM, IF/ID (FETCH_PERF_CNT_EN adds counters)
module fetch_stage
   import core_pkg::*;
#(
   parameter int           N        = N_DEFAULT,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   input  logic         PCSrc,
   input  logic [N-1:0] branch_target,
   output logic [N-1:0] imem_addr,
   input  logic [31:0]  imem_q,
   output logic [31:0]  instr_d,
   output logic [N-1:0] pc_d,
   output logic         valid_d
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]  fetch_count,
   output logic [31:0]  stall_count
`endif
);

   fetch_state_t state, state_next;
   logic [N-1:0] pc;
   logic         hlt_fire;
   logic         pc_adv;
   logic         ifid_en;
   logic         ifid_clr;
   logic         unused_tgt_bits;

   assign unused_tgt_bits = ^branch_target[1:0];
   assign imem_addr       = pc;

   // HLT only counts when this cycle's fetch would actually be loaded.
   assign hlt_fire = (state == RUN) && !stall && !flush && !PCSrc && (imem_q == INSTR_HLT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (hlt_fire) state_next = HALTED;
         HALTED:  if (PCSrc)    state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_comb begin
      pc_adv   = (state == RUN) && !stall && !PCSrc && !hlt_fire;
      ifid_clr = flush || PCSrc || (state == HALTED);
      ifid_en  = !stall;
   end

   // A redirect wins over stall: it comes from an older instruction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else if (PCSrc) begin
         pc <= {branch_target[N-1:2], 2'b00};
      end else if (pc_adv) begin
         pc <= pc + N'(4);
      end
   end

   ifid_reg #(.N(N)) u_ifid (
      .clk     (clk),
      .reset   (reset),
      .en      (ifid_en),
      .clr     (ifid_clr),
      .instr   (imem_q),
      .pc      (pc),
      .valid   (1'b1),
      .instr_r (instr_d),
      .pc_r    (pc_d),
      .valid_r (valid_d)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (ifid_en && !ifid_clr) fetch_count <= fetch_count + 32'd1;
         if (stall)                stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage against a behavioural model
module tb_fetch_stage;

   localparam logic [31:0] HLT = 32'hD440_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        PCSrc = 1'b0;
   logic [63:0] branch_target = '0;
   logic [63:0] imem_addr;
   logic [31:0] imem_q;
   logic [31:0] instr_d;
   logic [63:0] pc_d;
   logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   logic [31:0] mem [256];
   assign imem_q = mem[imem_addr[9:2]];

   int compares = 0;
   int errors   = 0;

   fetch_stage #(.N(64), .RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .flush         (flush),
      .PCSrc         (PCSrc),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_q        (imem_q),
      .instr_d       (instr_d),
      .pc_d          (pc_d),
      .valid_d       (valid_d)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count),
      .stall_count   (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compares++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: PC, halted flag, IF/ID contents, counters.
   logic [63:0] m_pc;
   logic        m_halt;
   logic [31:0] m_instr;
   logic [63:0] m_pcd;
   logic        m_valid;
   logic [31:0] m_fc;
   logic [31:0] m_sc;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pc <= 64'h0; m_halt <= 1'b0;
         m_instr <= 32'h0; m_pcd <= 64'h0; m_valid <= 1'b0;
         m_fc <= 32'h0; m_sc <= 32'h0;
      end else begin
         if (PCSrc) begin
            m_pc   <= branch_target & ~64'h3;
            m_halt <= 1'b0;
         end else if (!stall && !m_halt) begin
            if (!flush && mem[m_pc[9:2]] == HLT) m_halt <= 1'b1;
            else m_pc <= m_pc + 64'd4;
         end
         if (flush || PCSrc || m_halt) begin
            m_instr <= 32'h0; m_pcd <= 64'h0; m_valid <= 1'b0;
         end else if (!stall) begin
            m_instr <= mem[m_pc[9:2]]; m_pcd <= m_pc; m_valid <= 1'b1;
            m_fc <= m_fc + 32'd1;
         end
         if (stall) m_sc <= m_sc + 32'd1;
      end
   end

   always @(negedge clk) begin
      check("imem_addr", imem_addr, m_pc);
      check("instr_d", {32'h0, instr_d}, {32'h0, m_instr});
      check("pc_d", pc_d, m_pcd);
      check("valid_d", {63'h0, valid_d}, {63'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", {32'h0, fetch_count}, {32'h0, m_fc});
      check("stall_count", {32'h0, stall_count}, {32'h0, m_sc});
`endif
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_addr"}, imem_addr, 64'h0);
      check({tag, "_instr"}, {32'h0, instr_d}, 64'h0);
      check({tag, "_pcd"}, pc_d, 64'h0);
      check({tag, "_valid"}, {63'h0, valid_d}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
      check({tag, "_fcnt"}, {32'h0, fetch_count}, 64'h0);
      check({tag, "_scnt"}, {32'h0, stall_count}, 64'h0);
`endif
   endtask

   task automatic async_reset_pulse(input string tag);
      #2 reset = 1'b0;
      #1 check_reset_state(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 256; i++) begin
         do w = $urandom; while (w == HLT);
         mem[i] = w;
      end
      mem[0] = 32'hF842_D335;
      mem[1] = 32'hF847_9479;

      @(negedge clk);
      check_reset_state("reset");
      reset = 1'b1;

      step();
      check("e1_addr", imem_addr, 64'h4);
      check("e1_instr", {32'h0, instr_d}, 64'hF842_D335);
      check("e1_pcd", pc_d, 64'h0);
      check("e1_valid", {63'h0, valid_d}, 64'h1);
      step();
      check("e2_addr", imem_addr, 64'h8);
      check("e2_instr", {32'h0, instr_d}, 64'hF847_9479);
      check("e2_pcd", pc_d, 64'h4);

      stall = 1'b1;
      repeat (3) begin
         step();
         check("stall_addr", imem_addr, 64'h8);
         check("stall_pcd", pc_d, 64'h4);
         check("stall_instr", {32'h0, instr_d}, 64'hF847_9479);
      end
      stall = 1'b0;
      step();
      check("rel_instr", {32'h0, instr_d}, {32'h0, mem[2]});
      check("rel_pcd", pc_d, 64'h8);
      step();
      check("at10_addr", imem_addr, 64'h10);

      PCSrc = 1'b1; branch_target = 64'h103; stall = 1'b1;
      step();
      check("redir_addr", imem_addr, 64'h100);
      check("redir_valid", {63'h0, valid_d}, 64'h0);
      PCSrc = 1'b0; stall = 1'b0;
      step();
      check("redir_pcd", pc_d, 64'h100);
      check("redir_valid2", {63'h0, valid_d}, 64'h1);

      mem[3] = HLT;
      PCSrc = 1'b1; branch_target = 64'hC;
      step();
      PCSrc = 1'b0;
      step();
      check("hlt_pcd", pc_d, 64'hC);
      check("hlt_instr", {32'h0, instr_d}, {32'h0, HLT});
      check("hlt_valid", {63'h0, valid_d}, 64'h1);
      repeat (5) begin
         step();
         check("halt_addr", imem_addr, 64'hC);
         check("halt_valid", {63'h0, valid_d}, 64'h0);
      end
      PCSrc = 1'b1; branch_target = 64'h40;
      step();
      check("resume_addr", imem_addr, 64'h40);
      PCSrc = 1'b0;
      step();
      check("resume_pcd", pc_d, 64'h40);
      check("resume_valid", {63'h0, valid_d}, 64'h1);

      PCSrc = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step();
      PCSrc = 1'b0;
      step();
      check("wrap_addr", imem_addr, 64'h0);
      check("wrap_pcd", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
      flush = 1'b1; stall = 1'b1;
      step();
      check("flush_valid", {63'h0, valid_d}, 64'h0);
      check("flush_addr", imem_addr, 64'h0);
      flush = 1'b0; stall = 1'b0;
      step();

      async_reset_pulse("midrst");
      step();

      for (int i = 20; i < 256; i++)
         if ($urandom_range(0, 11) == 0) mem[i] = HLT;
      for (int c = 0; c < 3000; c++) begin
         stall         = ($urandom_range(0, 3) == 0);
         flush         = ($urandom_range(0, 9) == 0);
         PCSrc         = ($urandom_range(0, 9) == 0);
         branch_target = {$urandom, $urandom};
         if ($urandom_range(0, 299) == 0) async_reset_pulse("rndrst");
         else step();
      end
      stall = 1'b0; flush = 1'b0; PCSrc = 1'b0;

      PCSrc = 1'b1; branch_target = 64'hC;
      step();
      PCSrc = 1'b0;
      step();
      step();
      check("prehalt_addr", imem_addr, 64'hC);
      async_reset_pulse("haltrst");
      step();
      check("posthalt_addr", imem_addr, 64'h4);
      check("posthalt_pcd", pc_d, 64'h0);
      check("posthalt_valid", {63'h0, valid_d}, 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 core. Holds the PC, drives the instruction-memory address, selects the sequential or redirected next PC, and registers the fetched word and its PC into the IF/ID pipeline register. Decode and the sign-extension unit consume its outputs. A stall holds the stage, a flush inserts a bubble, and a fetched HLT parks the stage until a redirect arrives.

## Interface
Parameters:
- N, 64: PC and address width.
- RESET_PC, 64'h0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  squash: IF/ID loads a bubble.
- PCSrc  in  1  redirect request from the branch-resolution stage.
- branch_target  in  N  redirect address. Bits [1:0] are ignored and treated as 00.
- imem_addr  out  N  current PC, driven to the combinational instruction memory.
- imem_q  in  32  instruction word at imem_addr, same cycle.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  N  IF/ID PC.
- valid_d  out  1  IF/ID entry holds a real instruction.

## Operation
- States: RUN, HALTED.
- RUN:
  - next_pc = PCSrc ? {branch_target[N-1:2],2'b00} : pc+4.
  - The addition wraps modulo 2^N, so pc = 2^N-4 is followed by 0.
- Entry to HALTED: in RUN, with stall=0, flush=0, PCSrc=0 and imem_q == 32'hD4400000 (HLT).
  - HLT is latched into IF/ID with valid_d=1.
  - PC holds.
  - State becomes HALTED.
- HALTED:
  - PC holds.
  - IF/ID loads a bubble every cycle.
  - PCSrc=1 loads the target and returns to RUN. The HLT is considered squashed.
  - Only a redirect or reset leaves HALTED.
- Priority, per cycle:
  - PC update: PCSrc > stall > normal advance. A redirect is never lost to a stall, because it comes from an older instruction.
  - IF/ID update: flush > stall > load.
  - PCSrc=1 also forces an IF/ID bubble, even without flush.
- Load: instr_d<=imem_q, pc_d<=pc, valid_d<=1.
- Bubble: instr_d<=32'h0, pc_d<=0, valid_d<=0.
- Stall with no flush and no redirect: all IF/ID fields hold.
- HLT detection is suppressed while stall=1. The word is re-examined when the stall releases.

## Timing
- Reset (asynchronous, immediate, also mid-operation):
  - pc=RESET_PC, so imem_addr=RESET_PC.
  - instr_d=0, pc_d=0, valid_d=0.
  - State RUN.
  - Counters, when configured, =0.
- First rising edge after reset deasserts: IF/ID holds the word at RESET_PC.
- Latency: one cycle from imem_addr to instr_d/pc_d.
- Redirect: PCSrc sampled at edge k gives imem_addr=target after edge k, and instr_d=mem[target] after edge k+1.
- Redirect penalty: valid_d=0 for exactly one cycle.
- Outputs change only on rising clk or asynchronous reset. There are no combinational input-to-output paths except imem_q→(internal HLT compare).

## Configuration
- FETCH_PERF_CNT_EN defined:
  - Adds outputs fetch_count [31:0] and stall_count [31:0].
  - fetch_count increments on every IF/ID load with valid_d<=1.
  - stall_count increments on every cycle with stall=1.
  - Both wrap at 2^32 and clear on reset.
- FETCH_PERF_CNT_EN undefined: no counters and no extra ports. Behaviour is otherwise identical.

## Structure
- Shared package core_pkg:
  - N default.
  - Constants INSTR_NOP (32'h0) and INSTR_HLT (32'hD4400000).
  - Enum fetch_state_t {RUN, HALTED}.
- Sub-module ifid_reg:
  - Asynchronous active-low reset register for {instr, pc, valid}.
  - Inputs en (load) and clr (bubble); clr has priority.
  - Reused later for the other pipeline registers.
- PC register, next-PC mux and FSM live in fetch_stage.

## Test plan
- Reset, then free-run with mem[0]=32'hF842D335 and mem[1]=32'hF8479479:
  - imem_addr goes 0 → 4 → 8.
  - After edge 1: instr_d=F842D335, pc_d=0, valid_d=1.
  - After edge 2: instr_d=F8479479, pc_d=4.
- At PC=8, stall=1 for 3 cycles:
  - imem_addr stays 8 and instr_d/pc_d hold.
  - Release gives instr_d=mem[2], pc_d=8.
- Redirect:
  - PCSrc=1 with branch_target=64'h103 at PC=0x10, together with stall=1.
  - Next imem_addr=0x100 and valid_d=0.
  - One cycle later: pc_d=0x100, valid_d=1.
- HLT:
  - mem[3]=D4400000: pc_d=0xC, instr_d=D4400000, valid_d=1, then bubbles.
  - imem_addr frozen at 0xC for 5+ cycles.
  - PCSrc=1 with target 0x40 resumes from 0x40.
- Wrap and flush:
  - Redirect to 64'hFFFF_FFFF_FFFF_FFFC: next imem_addr=0.
  - flush=1 together with stall=1: bubble, valid_d=0.
- Reset asserted mid-stream and mid-HALTED:
  - Outputs zero immediately, without a clock edge.
  - imem_addr=RESET_PC and the state returns to RUN.
  - With FETCH_PERF_CNT_EN: both counters read 0.
